// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and constants for the data RAM arbiter (ARB_RR_EN selects round-robin).
package data_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbAccess = 2'd1,
    ArbResp   = 2'd2
  } arb_state_e;

  localparam logic Master0 = 1'b0;
  localparam logic Master1 = 1'b1;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam int unsigned ArbCntW = 4;

endpackage

// File: rtl/data_ram_arbiter_arb_pick.sv
// Combinational winner selection for the data RAM arbiter.
// ARB_RR_EN: round-robin on the last-grant pointer; otherwise fixed priority with MAX_CONSEC limit.
module data_ram_arbiter_arb_pick
  import data_ram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic [1:0]         req_i,
  input  logic [ArbCntW-1:0] arb_i,
  output logic               win_o
);

`ifdef ARB_RR_EN
  // arb_i holds the last granted master: zero = m0, nonzero = m1
  always_comb begin
    win_o = Master0;
    if (req_i == 2'b11) begin
      win_o = (arb_i != '0) ? Master0 : Master1;
    end else if (req_i[1]) begin
      win_o = Master1;
    end
  end
`else
  localparam logic [ArbCntW-1:0] MaxConsec = ArbCntW'(MAX_CONSEC);

  // arb_i is the count of back-to-back m0 grants while m1 was waiting
  always_comb begin
    win_o = Master0;
    if (req_i[1] && (!req_i[0] || (arb_i >= MaxConsec))) begin
      win_o = Master1;
    end
  end
`endif

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the byte-banked data RAM between the CPU MEM stage (m0) and the loader port (m1).
// Define ARB_RR_EN for round-robin arbitration instead of fixed priority.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_stallreq_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,

  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,

  output logic [1:0]  grant_o
);

  // state     | meaning
  // ArbIdle   | no transaction; arbitrates and latches the winner when any req is high
  // ArbAccess | RAM cycle for the latched winner; read data captured at its end
  // ArbResp   | winner's ack pulse, data_o valid

`ifdef ARB_RR_EN
  localparam logic [ArbCntW-1:0] ArbRst = ArbCntW'(1);
`else
  localparam logic [ArbCntW-1:0] ArbRst = '0;
  localparam logic [ArbCntW-1:0] MaxConsec = ArbCntW'(MAX_CONSEC);
`endif

  arb_state_e state_q, state_d;

  logic               win_q, win_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [ArbCntW-1:0] arb_q, arb_d;
  logic [1:0]         grant_q, grant_d;
  logic [31:0]        m0_rdata_q, m0_rdata_d;
  logic [31:0]        m1_rdata_q, m1_rdata_d;
  logic               m0_ack_q, m0_ack_d;
  logic               m1_ack_q, m1_ack_d;

  logic [1:0] req;
  logic       pick;
  logic       grant_now;
  logic       ce;

  assign req       = {m1_req_i, m0_req_i};
  assign grant_now = (state_q == ArbIdle) && (|req);

  data_ram_arbiter_arb_pick #(
    .MAX_CONSEC (MAX_CONSEC)
  ) u_arb_pick (
    .req_i (req),
    .arb_i (arb_q),
    .win_o (pick)
  );

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    grant_d    = grant_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;

    case (state_q)
      ArbIdle: begin
        if (|req) begin
          win_d   = pick;
          grant_d = (pick == Master1) ? 2'b10 : 2'b01;
          if (pick == Master1) begin
            we_d    = m1_we_i;
            addr_d  = m1_addr_i;
            sel_d   = m1_sel_i;
            wdata_d = m1_data_i;
          end else begin
            we_d    = m0_we_i;
            addr_d  = m0_addr_i;
            sel_d   = m0_sel_i;
            wdata_d = m0_data_i;
          end
          state_d = ArbAccess;
        end
      end
      ArbAccess: begin
        // writes return zero on data_o so stale read data never pairs with a write ack
        if (win_q == Master1) begin
          m1_rdata_d = we_q ? ZeroWord : ram_data_i;
          m1_ack_d   = 1'b1;
        end else begin
          m0_rdata_d = we_q ? ZeroWord : ram_data_i;
          m0_ack_d   = 1'b1;
        end
        state_d = ArbResp;
      end
      ArbResp: begin
        grant_d = 2'b00;
        state_d = ArbIdle;
      end
      default: begin
        grant_d = 2'b00;
        state_d = ArbIdle;
      end
    endcase
  end

`ifdef ARB_RR_EN
  always_comb begin
    arb_d = arb_q;
    if (grant_now) begin
      arb_d = {{(ArbCntW-1){1'b0}}, pick};
    end
  end
`else
  always_comb begin
    arb_d = arb_q;
    if (!m1_req_i) begin
      arb_d = '0;
    end else if (grant_now) begin
      if (pick == Master1) begin
        arb_d = '0;
      end else if (arb_q < MaxConsec) begin
        arb_d = arb_q + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ArbIdle;
      win_q      <= Master0;
      we_q       <= 1'b0;
      addr_q     <= ZeroWord;
      sel_q      <= 4'b0000;
      wdata_q    <= ZeroWord;
      arb_q      <= ArbRst;
      grant_q    <= 2'b00;
      m0_rdata_q <= ZeroWord;
      m1_rdata_q <= ZeroWord;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      arb_q      <= arb_d;
      grant_q    <= grant_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
    end
  end

  // rst gates the enable combinationally so a reset landing in ArbAccess commits nothing
  assign ce = (state_q == ArbAccess) & ~rst;

  assign ram_ce_o   = ce;
  assign ram_we_o   = ce & we_q;
  assign ram_addr_o = ce ? addr_q : ZeroWord;
  assign ram_sel_o  = ce ? sel_q : 4'b0000;
  assign ram_data_o = ce ? wdata_q : ZeroWord;

  assign grant_o       = grant_q;
  assign m0_ack_o      = m0_ack_q;
  assign m1_ack_o      = m1_ack_q;
  assign m0_data_o     = m0_rdata_q;
  assign m1_data_o     = m1_rdata_q;
  assign m0_stallreq_o = m0_req_i & ~m0_ack_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter with a byte-banked RAM and a word-level reference memory.
module tb_data_ram_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_data_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_data_o;
  logic        m0_ack_o, m0_stallreq_o;
  logic        m1_req_i, m1_we_i;
  logic [31:0] m1_addr_i, m1_data_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_data_o;
  logic        m1_ack_o;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16] = '{default: 32'h0};
  logic [31:0] ref_mem [16];
  int last_m;
  int streak;

  always #5 clk = ~clk;

  data_ram_arbiter #(.MAX_CONSEC(MAX)) dut (
    .clk           (clk),
    .rst           (rst),
    .m0_req_i      (m0_req_i),
    .m0_we_i       (m0_we_i),
    .m0_addr_i     (m0_addr_i),
    .m0_sel_i      (m0_sel_i),
    .m0_data_i     (m0_data_i),
    .m0_data_o     (m0_data_o),
    .m0_ack_o      (m0_ack_o),
    .m0_stallreq_o (m0_stallreq_o),
    .m1_req_i      (m1_req_i),
    .m1_we_i       (m1_we_i),
    .m1_addr_i     (m1_addr_i),
    .m1_sel_i      (m1_sel_i),
    .m1_data_i     (m1_data_i),
    .m1_data_o     (m1_data_o),
    .m1_ack_o      (m1_ack_o),
    .ram_ce_o      (ram_ce_o),
    .ram_we_o      (ram_we_o),
    .ram_addr_o    (ram_addr_o),
    .ram_sel_o     (ram_sel_o),
    .ram_data_o    (ram_data_o),
    .ram_data_i    (ram_data_i),
    .grant_o       (grant_o)
  );

  assign ram_data_i = mem[ram_addr_o[5:2]];

  always @(posedge clk) begin
    if (ram_ce_o && ram_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_sel_o[b]) mem[ram_addr_o[5:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  task automatic drive(input int m, input logic rq, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    if (m == 0) begin
      m0_req_i = rq; m0_we_i = we; m0_addr_i = a; m0_sel_i = s; m0_data_i = d;
    end else begin
      m1_req_i = rq; m1_we_i = we; m1_addr_i = a; m1_sel_i = s; m1_data_i = d;
    end
  endtask

  // One complete transaction from an idle arbiter; starts and ends just after a falling edge.
  task automatic txn(input int m, input logic we, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d);
    int cyc;
    logic acked;
    logic [31:0] exp_d;
    exp_d = we ? 32'h0 : ref_mem[a[5:2]];
    drive(m, 1'b1, we, a, s, d);
    #1;
    if (m == 0) check("stall_req_cycle", 32'(m0_stallreq_o), 32'(1));
    cyc = 1;
    acked = 1'b0;
    while (!acked && cyc < 8) begin
      @(negedge clk);
      cyc++;
      acked = (m == 0) ? m0_ack_o : m1_ack_o;
      check("ram_ce", 32'(ram_ce_o), 32'(cyc == 2));
      if (cyc == 2) begin
        check("grant", 32'(grant_o), 32'((m == 0) ? 2'b01 : 2'b10));
        check("ram_we", 32'(ram_we_o), 32'(we));
        check("ram_addr", ram_addr_o, a);
        check("ram_sel", 32'(ram_sel_o), 32'(s));
        if (we) check("ram_wdata", ram_data_o, d);
      end
      if (m == 0) check("stallreq", 32'(m0_stallreq_o), 32'(cyc < 3));
    end
    check("latency", 32'(cyc), 32'(3));
    check("rdata", (m == 0) ? m0_data_o : m1_data_o, exp_d);
    check("other_ack", 32'((m == 0) ? m1_ack_o : m0_ack_o), 32'(0));
    drive(m, 1'b0, we, a, s, d);
    if (we) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
    last_m = m;
    streak = 0;
    @(negedge clk);
    check("ack_cleared", 32'((m == 0) ? m0_ack_o : m1_ack_o), 32'(0));
    check("grant_idle", 32'(grant_o), 32'(0));
    check("rdata_hold", (m == 0) ? m0_data_o : m1_data_o, exp_d);
  endtask

  initial begin
    int ng;
    int cyc;
    int exp_m;
    logic [31:0] exp_w;

    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    last_m = 1;
    streak = 0;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);

    check("rst_m0_ack", 32'(m0_ack_o), 32'(0));
    check("rst_m1_ack", 32'(m1_ack_o), 32'(0));
    check("rst_grant", 32'(grant_o), 32'(0));
    check("rst_ram_ce", 32'(ram_ce_o), 32'(0));
    check("rst_ram_we", 32'(ram_we_o), 32'(0));
    check("rst_ram_addr", ram_addr_o, 32'h0);
    check("rst_ram_sel", 32'(ram_sel_o), 32'(0));
    check("rst_ram_data", ram_data_o, 32'h0);
    check("rst_m0_data", m0_data_o, 32'h0);
    check("rst_m1_data", m1_data_o, 32'h0);
    check("rst_stall", 32'(m0_stallreq_o), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    txn(0, 1'b1, 32'h0, 4'hF, 32'h4455_6677);
    txn(0, 1'b0, 32'h0, 4'hF, 32'h0);

    txn(0, 1'b1, 32'h0, 4'b0100, 32'h00EE_0000);
    txn(0, 1'b0, 32'h0, 4'hF, 32'h0);
    check("byte_merge_word0", mem[0], 32'h44EE_6677);

    txn(1, 1'b1, 32'h4, 4'hF, 32'hAABB_CCDD);
    check("m1_write_word1", mem[1], 32'hAABB_CCDD);
    txn(0, 1'b1, 32'h8, 4'hF, 32'h1234_5678);

    for (int i = 0; i < 40; i++) begin
      txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          {26'h0, 4'($urandom_range(0, 15)), 2'b00}, 4'($urandom_range(0, 15)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 16; i++) check("mem_vs_model", mem[i], ref_mem[i]);

    // m0 abandons its request mid-transaction; the access still completes
    drive(0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    @(negedge clk);
    check("drop_ce", 32'(ram_ce_o), 32'(1));
    drive(0, 1'b0, 1'b0, 32'h4, 4'hF, 32'h0);
    @(negedge clk);
    check("drop_ack", 32'(m0_ack_o), 32'(1));
    check("drop_rdata", m0_data_o, ref_mem[1]);
    @(negedge clk);
    check("drop_ack_clear", 32'(m0_ack_o), 32'(0));
    check("drop_grant_idle", 32'(grant_o), 32'(0));
    txn(1, 1'b0, 32'h4, 4'hF, 32'h0);

    // reset landing in the access cycle of a write
    exp_w = ref_mem[2];
    drive(0, 1'b1, 1'b1, 32'h8, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    check("rstacc_pre_ce", 32'(ram_ce_o), 32'(1));
    rst = 1'b1;
    #1;
    check("rstacc_ce_off", 32'(ram_ce_o), 32'(0));
    check("rstacc_we_off", 32'(ram_we_o), 32'(0));
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("rstacc_word2", mem[2], exp_w);
    check("rstacc_no_ack", 32'(m0_ack_o), 32'(0));
    check("rstacc_grant", 32'(grant_o), 32'(0));
    rst = 1'b0;
    last_m = 1;
    streak = 0;
    @(negedge clk);
    check("rstacc_no_ack_after", 32'(m0_ack_o), 32'(0));
    check("rstacc_word2_after", mem[2], exp_w);

    // both masters reading back-to-back
    drive(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    ng = 0;
    cyc = 0;
    while (ng < 12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ram_ce_o) begin
`ifdef ARB_RR_EN
        exp_m = (last_m == 0) ? 1 : 0;
`else
        exp_m = (streak >= MAX) ? 1 : 0;
`endif
        check("arb_grant", 32'(grant_o), 32'((exp_m == 1) ? 2'b10 : 2'b01));
        if (exp_m == 1) streak = 0;
        else streak++;
        last_m = exp_m;
        ng++;
      end
      if (m0_ack_o) check("arb_m0_rdata", m0_data_o, ref_mem[0]);
      if (m1_ack_o) check("arb_m1_rdata", m1_data_o, ref_mem[1]);
    end
    check("arb_grant_count", 32'(ng), 32'(12));
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("arb_end_grant", 32'(grant_o), 32'(0));
    txn(1, 1'b0, 32'h0, 4'hF, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
